// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer behind the UART receiver.
// Each entry holds one frame plus its parity/stop error flags; occupancy and sticky overflow are reported.
module uart_rx_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] P_data,
  input  logic                  data_valid,
  input  logic                  par_err,
  input  logic                  stp_err,
  input  logic                  rd_en,
  input  logic                  ovf_clr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_par_err,
  output logic                  rd_stp_err,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow
);

  localparam int ENTRY_WIDTH = DATA_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT    = (ADDR_WIDTH + 1)'(AF_LEVEL);

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [ENTRY_WIDTH-1:0] head_entry;

  logic [ADDR_WIDTH-1:0] wr_ptr_reg;
  logic [ADDR_WIDTH-1:0] rd_ptr_reg;
  logic [ADDR_WIDTH:0]   count_reg;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  overflow_reg;
  logic                  overflow_next;

  logic push;
  logic pop;
  logic drop;

  // Status flags come only from the count register, never from pointer compares.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == DEPTH_CNT);
  assign almost_full = (count_reg >= AF_CNT);
  assign count       = count_reg;
  assign overflow    = overflow_reg;

  // A full FIFO still accepts a frame when a pop frees a slot in the same cycle.
  assign push = data_valid & (~full | rd_en);
  assign pop  = rd_en & ~empty;
  assign drop = data_valid & full & ~rd_en;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // A new drop takes priority over a clear requested in the same cycle.
  always_comb begin
    overflow_next = overflow_reg;
    if (drop) begin
      overflow_next = 1'b1;
    end else if (ovf_clr) begin
      overflow_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg    <= count_next;
      overflow_reg <= overflow_next;
    end
  end

  // Storage is deliberately left unreset; contents are meaningless while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= {stp_err, par_err, P_data};
    end
  end

  assign head_entry = mem[rd_ptr_reg];
  assign rd_data    = head_entry[DATA_WIDTH-1:0];
  assign rd_par_err = head_entry[DATA_WIDTH];
  assign rd_stp_err = head_entry[DATA_WIDTH+1];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a queue-based reference model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int AF    = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] P_data;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;
  logic          rd_en;
  logic          ovf_clr;
  logic [DW-1:0] rd_data;
  logic          rd_par_err;
  logic          rd_stp_err;
  logic          empty;
  logic          full;
  logic          almost_full;
  logic [AW:0]   count;
  logic          overflow;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model: queue of {stp, par, data} entries and a sticky overflow bit.
  logic [DW+1:0] model_q[$];
  logic          model_ovf = 1'b0;

  uart_rx_fifo #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .AF_LEVEL(AF)
  ) dut (
    .clk(clk), .rst(rst), .P_data(P_data), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err), .rd_en(rd_en), .ovf_clr(ovf_clr),
    .rd_data(rd_data), .rd_par_err(rd_par_err), .rd_stp_err(rd_stp_err),
    .empty(empty), .full(full), .almost_full(almost_full), .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge, updating the model from the inputs held across that edge.
  task automatic tick();
    int  sz;
    bit  m_full;
    bit  m_push;
    bit  m_pop;
    sz     = model_q.size();
    m_full = (sz == DEPTH);
    m_push = data_valid && (!m_full || rd_en);
    m_pop  = rd_en && (sz > 0);
    @(posedge clk);
    if (rst) begin
      if (m_pop) void'(model_q.pop_front());
      if (m_push) model_q.push_back({stp_err, par_err, P_data});
      if (data_valid && m_full && !rd_en) model_ovf = 1'b1;
      else if (ovf_clr) model_ovf = 1'b0;
    end
    #1;
  endtask

  task automatic push_byte(input logic [DW-1:0] d, input logic pe, input logic se);
    P_data = d; par_err = pe; stp_err = se; data_valid = 1'b1;
    tick();
    data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Cycle-by-cycle compare of DUT against the model, away from the active edge.
  always @(negedge clk) begin
    int sz;
    sz = model_q.size();
    chk("cyc_count", 32'(count), 32'(sz));
    chk("cyc_empty", 32'(empty), 32'(sz == 0));
    chk("cyc_full", 32'(full), 32'(sz == DEPTH));
    chk("cyc_almost_full", 32'(almost_full), 32'(sz >= AF));
    chk("cyc_overflow", 32'(overflow), 32'(model_ovf));
    if (sz > 0) begin
      chk("cyc_head", 32'({rd_stp_err, rd_par_err, rd_data}), 32'(model_q[0]));
    end
  end

  initial begin
    rst = 1'b0; P_data = '0; data_valid = 1'b0; par_err = 1'b0; stp_err = 1'b0;
    rd_en = 1'b0; ovf_clr = 1'b0;

    // Reset then idle
    repeat (3) tick();
    rst = 1'b1;
    tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rd_en = 1'b1;
    repeat (2) tick();
    rd_en = 1'b0;
    chk("idle_rd_count", 32'(count), 32'd0);

    // Single frame with parity error
    push_byte(8'hA5, 1'b1, 1'b0);
    chk("single_empty", 32'(empty), 32'd0);
    chk("single_count", 32'(count), 32'd1);
    chk("single_data", 32'(rd_data), 32'h A5);
    chk("single_par", 32'(rd_par_err), 32'd1);
    chk("single_stp", 32'(rd_stp_err), 32'd0);
    pop_one();
    chk("single_pop_empty", 32'(empty), 32'd1);
    chk("single_pop_count", 32'(count), 32'd0);

    // Fill and check almost_full threshold
    for (int i = 0; i < DEPTH; i++) begin
      push_byte(8'(i), 1'(i % 2), 1'((i / 2) % 2));
      if (i == 10) chk("af_before", 32'(almost_full), 32'd0);
      if (i == 11) chk("af_at_12", 32'(almost_full), 32'd1);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_count", 32'(count), 32'd16);

    // Overflow while full, then clear; then set-wins-over-clear
    push_byte(8'hFF, 1'b0, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_head", 32'(rd_data), 32'h00);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", 32'(overflow), 32'd0);
    ovf_clr = 1'b1;
    push_byte(8'hEE, 1'b0, 1'b0);
    ovf_clr = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;

    // Full with simultaneous push and pop
    rd_en = 1'b1;
    push_byte(8'h77, 1'b0, 1'b1);
    rd_en = 1'b0;
    chk("fpp_count", 32'(count), 32'd16);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_head", 32'(rd_data), 32'h01);
    for (int i = 1; i < DEPTH; i++) begin
      chk("order", 32'(rd_data), 32'(i));
      pop_one();
    end
    chk("fpp_tail_data", 32'(rd_data), 32'h77);
    chk("fpp_tail_stp", 32'(rd_stp_err), 32'd1);
    pop_one();
    chk("drain_empty", 32'(empty), 32'd1);

    // Simultaneous push and pop while empty: only the push happens
    rd_en = 1'b1;
    push_byte(8'h5A, 1'b0, 1'b0);
    rd_en = 1'b0;
    chk("epp_count", 32'(count), 32'd1);
    chk("epp_data", 32'(rd_data), 32'h5A);
    pop_one();

    // Reset mid-operation, asserted between edges
    for (int i = 0; i < 5; i++) push_byte(8'h10 + 8'(i), 1'b0, 1'b0);
    chk("pre_rst_count", 32'(count), 32'd5);
    #2;
    rst = 1'b0;
    model_q.delete();
    model_ovf = 1'b0;
    #1;
    chk("midrst_count", 32'(count), 32'd0);
    chk("midrst_empty", 32'(empty), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    push_byte(8'h3C, 1'b0, 1'b0);
    chk("post_rst_head", 32'(rd_data), 32'h3C);
    chk("post_rst_count", 32'(count), 32'd1);

    // Mixed traffic pattern exercising wraparound, drops and clears against the model
    for (int i = 0; i < 200; i++) begin
      data_valid = ((i % 3) != 2);
      rd_en      = ((i % 7) == 0) || (i > 120 && (i % 2) == 0);
      ovf_clr    = ((i % 29) == 0);
      P_data     = 8'(i * 37);
      par_err    = 1'(i % 5 == 0);
      stp_err    = 1'(i % 11 == 0);
      tick();
    end
    data_valid = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
